// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - shares one burst bmem port between the I-cache and D-cache line ports
// Define BMEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise D-side has fixed priority.
module bmem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_DATA,
        S_WR_BURST,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_cnt;
    logic         r_owner_d;
    logic [31:0]  r_addr;
    logic [255:0] r_wline;
    logic [255:0] r_line;
    logic [255:0] r_i_rdata;
    logic [255:0] r_d_rdata;

    logic         w_i_req;
    logic         w_d_req;
    logic         w_grant;
    logic         w_grant_d;
    logic         w_d_wr;
    logic [31:0]  w_sel_addr;
    logic         w_beat_ok;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_grant = w_i_req | w_d_req;

`ifdef BMEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // On a conflict the side that did not win last time takes the port.
    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && w_grant) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    // A D-side request with d_write set is a writeback even if d_read is also high.
    assign w_d_wr     = w_grant_d & d_write;
    assign w_sel_addr = w_grant_d ? d_addr : i_addr;
    assign w_beat_ok  = bmem_rvalid && (bmem_raddr == r_addr);

    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

    always_comb begin
        w_next     = r_state;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_d_wr ? S_WR_BURST : S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                bmem_read = 1'b1;
                bmem_addr = r_addr;
                if (bmem_ready) begin
                    w_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (w_beat_ok && r_cnt == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = r_addr;
                bmem_wdata = r_wline[{r_cnt, 6'd0} +: 64];
                if (bmem_ready && r_cnt == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                i_resp = ~r_owner_d;
                d_resp = r_owner_d;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_wline   <= '0;
            r_line    <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner_d <= w_grant_d;
                        r_addr    <= w_sel_addr & 32'hFFFF_FFE0;
                        r_cnt     <= '0;
                        if (w_d_wr) begin
                            r_wline <= d_wdata;
                        end
                    end
                end
                S_RD_ISSUE: r_cnt <= '0;
                S_RD_DATA: begin
                    if (w_beat_ok) begin
                        r_line[{r_cnt, 6'd0} +: 64] <= bmem_rdata;
                        r_cnt <= r_cnt + 2'd1;
                        // Publish the whole line only once the last beat lands.
                        if (r_cnt == 2'd3) begin
                            if (r_owner_d) begin
                                r_d_rdata <= {bmem_rdata, r_line[191:0]};
                            end else begin
                                r_i_rdata <= {bmem_rdata, r_line[191:0]};
                            end
                        end
                    end
                end
                S_WR_BURST: begin
                    if (bmem_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - scoreboard testbench for bmem_arbiter
`timescale 1ns/1ps
module tb_bmem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_read = 1'b0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr = '0;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;

    bmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic wr; logic both; logic [255:0] wdata; } req_t;
    typedef struct { logic side_d; logic wr; logic [31:0] addr; logic [255:0] line; } exp_t;
    typedef struct { logic v; logic good; logic [31:0] a; logic [63:0] d; } beat_t;

    req_t        iq[$];
    req_t        dq[$];
    exp_t        sb[$];
    beat_t       beats[$];
    logic [63:0] wexp[$];
    logic        ready_pat[$];

    int          checks = 0;
    int          failures = 0;
    int          rd_cycles = 0;
    int          good_beats = 0;
    logic        i_busy = 1'b0;
    logic        d_busy = 1'b0;
    logic        inject_bad = 1'b0;
    logic        wr_last_seen = 1'b0;
    logic [1:0]  wr_cnt = 2'd0;
    logic [255:0] last_d_line = '0;

    exp_t  env_e;
    req_t  env_r;
    beat_t env_b;
    logic  env_rdy;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int n);
        logic [7:0] p;
        p = 8'(8'h11 * (n + 1));
        return {8{p}} ^ {a, 32'h0};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int n = 0; n < 4; n++) l[64*n +: 64] = beat_data(a, n);
        return l;
    endfunction

    task automatic add_req_i(input logic [31:0] a);
        req_t r;
        r.addr = a; r.wr = 1'b0; r.both = 1'b0; r.wdata = '0;
        iq.push_back(r);
    endtask

    task automatic add_req_d(input logic [31:0] a, input logic wr, input logic both, input logic [255:0] wd);
        req_t r;
        r.addr = a; r.wr = wr; r.both = both; r.wdata = wd;
        dq.push_back(r);
    endtask

    task automatic push_exp(input logic side_d, input logic wr, input logic [31:0] a);
        exp_t e;
        e.side_d = side_d;
        e.wr     = wr;
        e.addr   = a & 32'hFFFF_FFE0;
        e.line   = wr ? last_d_line : line_of(e.addr);
        if (side_d && !wr) last_d_line = e.line;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (sb.size() > 0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        check({tag, "_complete"}, 256'(sb.size()), 256'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_rdata"}, i_rdata, 256'd0);
        check({tag, "_d_rdata"}, d_rdata, 256'd0);
        check({tag, "_ctl"}, {bmem_read, bmem_write, i_resp, d_resp}, 4'b0000);
        check({tag, "_bmem_addr"}, bmem_addr, 32'd0);
        check({tag, "_bmem_wdata"}, bmem_wdata, 64'd0);
    endtask

    // Requesters, memory model and response monitor, all acting on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_last_seen) begin
                check("d_resp_after_last_beat", d_resp, 1'b1);
                wr_last_seen = 1'b0;
            end
            if (i_resp || d_resp) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", {i_resp, d_resp}, 2'b00);
                end else begin
                    env_e = sb.pop_front();
                    check("resp_owner", {i_resp, d_resp}, env_e.side_d ? 2'b01 : 2'b10);
                    if (env_e.side_d) check(env_e.wr ? "d_rdata_hold" : "d_rdata", d_rdata, env_e.line);
                    else check("i_rdata", i_rdata, env_e.line);
                end
            end
            if (i_resp) begin i_read = 1'b0; i_busy = 1'b0; end
            if (d_resp) begin d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0; end
            if (!i_busy && iq.size() > 0) begin
                env_r = iq.pop_front();
                i_addr = env_r.addr; i_read = 1'b1; i_busy = 1'b1;
            end
            if (!d_busy && dq.size() > 0) begin
                env_r = dq.pop_front();
                d_addr = env_r.addr; d_write = env_r.wr; d_read = !env_r.wr || env_r.both;
                d_wdata = env_r.wdata; d_busy = 1'b1;
            end
            env_rdy = 1'b1;
            if ((bmem_read || bmem_write) && ready_pat.size() > 0) env_rdy = ready_pat.pop_front();
            bmem_ready = env_rdy;
            if (bmem_read) begin
                rd_cycles++;
                if (env_rdy) begin
                    if (sb.size() == 0) check("bmem_read_unexpected", 1'b1, 1'b0);
                    else check("bmem_addr_rd", bmem_addr, sb[0].addr);
                    for (int k = 0; k < 2; k++) begin
                        env_b.v = 1'b0; env_b.good = 1'b0; env_b.a = '0; env_b.d = '0;
                        beats.push_back(env_b);
                    end
                    for (int n = 0; n < 4; n++) begin
                        if (inject_bad && n == 2) begin
                            env_b.v = 1'b1; env_b.good = 1'b0;
                            env_b.a = bmem_addr ^ 32'h20; env_b.d = 64'hdead_beef_dead_beef;
                            beats.push_back(env_b);
                        end
                        env_b.v = 1'b1; env_b.good = 1'b1;
                        env_b.a = bmem_addr; env_b.d = beat_data(bmem_addr, n);
                        beats.push_back(env_b);
                    end
                    inject_bad = 1'b0;
                end
            end
            if (bmem_write) begin
                if (wexp.size() == 0) check("bmem_wdata_extra", 1'b1, 1'b0);
                else check("bmem_wdata", bmem_wdata, wexp.pop_front());
                if (env_rdy) begin
                    if (sb.size() > 0) check("bmem_addr_wr", bmem_addr, sb[0].addr);
                    if (wr_cnt == 2'd3) wr_last_seen = 1'b1;
                    wr_cnt = wr_cnt + 2'd1;
                end
            end
            if (beats.size() > 0) begin
                env_b = beats.pop_front();
                bmem_rvalid = env_b.v; bmem_raddr = env_b.a; bmem_rdata = env_b.d;
                if (env_b.v && env_b.good) good_beats++;
            end else begin
                bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
            end
        end
    end

    initial begin
        logic [255:0] wl;
        int c;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b1;

        // I-side read with unaligned address.
        @(posedge clk);
        rd_cycles = 0;
        add_req_i(32'h1eceb004);
        push_exp(1'b0, 1'b0, 32'h1eceb004);
        wait_done("i_read");
        check("i_read_cmd_cycles", 256'(rd_cycles), 256'd1);

        // Simultaneous requests, one each.
        @(posedge clk);
        add_req_i(32'h0000_0104);
        add_req_d(32'h0000_020c, 1'b0, 1'b0, '0);
        push_exp(1'b1, 1'b0, 32'h0000_020c);
        push_exp(1'b0, 1'b0, 32'h0000_0104);
        wait_done("conflict1");

        // Conflict again, D re-requests right after its first response.
        @(posedge clk);
        add_req_i(32'h0000_0300);
        add_req_d(32'h0000_0400, 1'b0, 1'b0, '0);
        add_req_d(32'h0000_0500, 1'b0, 1'b0, '0);
        push_exp(1'b1, 1'b0, 32'h0000_0400);
`ifdef BMEM_ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b0, 32'h0000_0300);
        push_exp(1'b1, 1'b0, 32'h0000_0500);
`else
        push_exp(1'b1, 1'b0, 32'h0000_0500);
        push_exp(1'b0, 1'b0, 32'h0000_0300);
`endif
        wait_done("conflict2");

        // D writeback with d_read also high, memory stalling one beat.
        @(posedge clk);
        for (int n = 0; n < 4; n++) wl[64*n +: 64] = {48'hd0d0_d0d0_d0d0, 16'(n)};
        add_req_d(32'h1eceb020, 1'b1, 1'b1, wl);
        wexp.push_back(wl[63:0]);
        wexp.push_back(wl[127:64]);
        wexp.push_back(wl[127:64]);
        wexp.push_back(wl[191:128]);
        wexp.push_back(wl[255:192]);
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b0);
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b1);
        ready_pat.push_back(1'b1);
        push_exp(1'b1, 1'b1, 32'h1eceb020);
        wait_done("d_write");
        check("d_write_beats_used", 256'(wexp.size()), 256'd0);

        // Read with a beat tagged for another line in the middle.
        @(posedge clk);
        inject_bad = 1'b1;
        add_req_i(32'h0000_406c);
        push_exp(1'b0, 1'b0, 32'h0000_406c);
        wait_done("mismatch");

        // Reset after beat 2 of a read, remaining beat arrives in IDLE.
        @(posedge clk);
        good_beats = 0;
        add_req_i(32'h0abc_d104);
        push_exp(1'b0, 1'b0, 32'h0abc_d104);
        c = 0;
        while (good_beats < 3 && c < 200) begin
            @(posedge clk);
            c++;
        end
        check("reset_beats_before", 256'(good_beats), 256'd3);
        #2 rst = 1'b0;
        #1 check_all_zero("mid_reset");
        sb.delete();
        iq.delete();
        i_read = 1'b0;
        i_busy = 1'b0;
        last_d_line = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        check("after_stray_i_rdata", i_rdata, 256'd0);
        add_req_i(32'h0abc_d204);
        push_exp(1'b0, 1'b0, 32'h0abc_d204);
        wait_done("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
